// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encoding, button indices and width helper for button_pulse
package button_pkg;

    // Per-button press/auto-repeat state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    localparam int UP      = 0;
    localparam int DOWN    = 1;
    localparam int LEFT    = 2;
    localparam int RIGHT   = 3;
    localparam int NUM_BTN = 4;

    // Counter width that holds values up to v-1; never narrower than one bit
    function automatic int cnt_width(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button: synchroniser, debounce counter, press/repeat FSM, step pulse
module btn_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int DW      = cnt_width(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = cnt_width(RPT_MAX);

    localparam logic [DW-1:0] DB_LAST      = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_MAX       = DW'(DEBOUNCE_CYCLES);
    localparam logic [RW-1:0] DELAY_LOAD   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LOAD  = RW'(REPEAT_PERIOD - 1);

    logic [1:0]    sync_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          level_q, level_d;
    btn_state_e    state_q, state_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          pulse_q, pulse_d;

    // Two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b00;
        else         sync_q <= {sync_q[0], raw_i};
    end

    // Count consecutive samples that disagree with the accepted level; flip when enough agree
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (sync_q[1] == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            level_d  = ~level_q;
            db_cnt_d = '0;
        end else if (db_cnt_q != DB_MAX) begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Press FSM: first pulse on debounced rise, then delay, then periodic repeat
    always_comb begin
        state_d = state_q;
        rpt_d   = rpt_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rpt_d = '0;
                if (level_q) begin
                    state_d = ST_HOLD;
                    pulse_d = 1'b1;
                    rpt_d   = DELAY_LOAD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!level_q) begin
                    state_d = ST_IDLE;
                    rpt_d   = '0;
                end else if (rpt_q == '0) begin
                    state_d = ST_REPEAT;
                    pulse_d = 1'b1;
                    rpt_d   = PERIOD_LOAD;
                end else begin
                    rpt_d = rpt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rpt_d   = '0;
            end
        endcase
    end

    // State, counters and pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            state_q  <= ST_IDLE;
            rpt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            state_q  <= state_d;
            rpt_q    <= rpt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/button_pulse.sv
// rtl/button_pulse.sv - four debounced push-buttons with auto-repeat step pulses
module button_pulse
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Bt_Up_Raw,
    input  logic       Bt_Down_Raw,
    input  logic       Bt_Left_Raw,
    input  logic       Bt_Right_Raw,
    output logic       Bt_Up,
    output logic       Bt_Down,
    output logic       Bt_Left,
    output logic       Bt_Right,
    output logic [3:0] Bt_Level
);

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] db_level;
    logic [NUM_BTN-1:0] db_pulse;
    logic [NUM_BTN-1:0] pulse_d, pulse_q;
    logic [NUM_BTN-1:0] level_q;

    assign raw_vec[UP]    = Bt_Up_Raw;
    assign raw_vec[DOWN]  = Bt_Down_Raw;
    assign raw_vec[LEFT]  = Bt_Left_Raw;
    assign raw_vec[RIGHT] = Bt_Right_Raw;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_btn (
            .clk_i  (Clk),
            .rst_ni (Rst_n),
            .raw_i  (raw_vec[g]),
            .level_o(db_level[g]),
            .pulse_o(db_pulse[g])
        );
    end

    // Opposing steps in the same cycle cancel each other; the FSMs keep running
    always_comb begin
        pulse_d = db_pulse;
        if (db_pulse[UP] && db_pulse[DOWN]) begin
            pulse_d[UP]   = 1'b0;
            pulse_d[DOWN] = 1'b0;
        end
        if (db_pulse[LEFT] && db_pulse[RIGHT]) begin
            pulse_d[LEFT]  = 1'b0;
            pulse_d[RIGHT] = 1'b0;
        end
    end

    // Output registers for levels and pulses
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            level_q <= '0;
            pulse_q <= '0;
        end else begin
            level_q <= db_level;
            pulse_q <= pulse_d;
        end
    end

    assign Bt_Level = level_q;
    assign Bt_Up    = pulse_q[UP];
    assign Bt_Down  = pulse_q[DOWN];
    assign Bt_Left  = pulse_q[LEFT];
    assign Bt_Right = pulse_q[RIGHT];

endmodule
